// File: rtl/regfile_wb_pkg.sv
// Shared defaults and the slot record for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int NUM_REGS    = 2 ** ADDR_W_DEF;

    // One pending write-back at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin grant over occupied slots; owns the rotating search pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] next_ptr;
    logic             found;
    int               idx;

    // Search starts at rr_ptr; the first occupied slot found wins.
    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                next_ptr              = PTR_W'((idx + 1) % NUM_REQ);
                found                 = 1'b1;
            end
        end
        rr_ptr_d = (found && advance) ? next_ptr : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Funnels several write-back requesters into the single register-file write port.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [2**ADDR_W-1:0]      pending_mask
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
    logic [ADDR_W-1:0]  slot_addr_q [NUM_REQ];
    logic [ADDR_W-1:0]  slot_addr_d [NUM_REQ];
    logic [DATA_W-1:0]  slot_data_q [NUM_REQ];
    logic [DATA_W-1:0]  slot_data_d [NUM_REQ];

    logic               rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

    logic [ADDR_W-1:0]  in_addr [NUM_REQ];
    logic [DATA_W-1:0]  in_data [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] conflict;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (slot_valid_q),
        .advance (|grant),
        .grant   (grant)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
            in_data[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Same-address writes must commit in acceptance order; lower index wins ties.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (in_addr[i] != '0) begin
                    if (j != i && slot_valid_q[j] && !grant[j] && slot_addr_q[j] == in_addr[i])
                        conflict[i] = 1'b1;
                    if (j < i && req_valid[j] && in_addr[j] == in_addr[i])
                        conflict[i] = 1'b1;
                end
            end
        end
        req_ready = (~slot_valid_q | grant) & ~conflict;
    end

    // Writes to register 0 are handshaken but never occupy a slot.
    always_comb begin
        slot_valid_d = slot_valid_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_data_d[i] = slot_data_q[i];
            if (grant[i]) slot_valid_d[i] = 1'b0;
            if (req_valid[i] && req_ready[i] && in_addr[i] != '0) begin
                slot_valid_d[i] = 1'b1;
                slot_addr_d[i]  = in_addr[i];
                slot_data_d[i]  = in_data[i];
            end
        end
    end

    always_comb begin
        rf_we_d    = |grant;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                rf_waddr_d = slot_addr_q[i];
                rf_wdata_d = slot_data_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // A register stays pending until the output stage has handed it to the file.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (slot_valid_q[i]) pending_mask[slot_addr_q[i]] = 1'b1;
        if (rf_we_q) pending_mask[rf_waddr_q] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of the write-back arbiter against an acceptance-log model.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int N       = 3;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int NREG    = 32;
    localparam int LOG_MAX = 4096;

    logic                clk   = 1'b0;
    logic                reset = 1'b0;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*AW-1:0]     req_addr;
    logic [N*DW-1:0]     req_data;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic [NREG-1:0]     pending_mask;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    // Every accepted nonzero-address write, in acceptance order.
    slot_t       log_q [LOG_MAX];
    int          log_n    = 0;
    int          log_base = 0;
    bit          consumed [LOG_MAX];

    int          drv_checks = 0, drv_errors = 0;
    int          mon_checks = 0, mon_errors = 0;
    logic [N-1:0] rdy_seen;
    logic [AW-1:0] col_addr = '0;
    logic [DW-1:0] col_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        drv_checks++;
        if (act !== exp) begin
            drv_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_addr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]   = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    // Called just after a negedge: log acceptances just before the posedge, return at next negedge.
    task automatic step();
        #4;
        rdy_seen = req_ready;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] && req_addr[i*AW +: AW] != '0 && log_n < LOG_MAX) begin
                log_q[log_n] = '{valid: 1'b1, addr: req_addr[i*AW +: AW], data: req_data[i*DW +: DW]};
                log_n++;
            end
        end
        @(negedge clk);
        if (rf_we && rf_waddr == col_addr) col_q.push_back(rf_wdata);
    endtask

    // Asserted between edges so the asynchronous clear is observed before any clock.
    task automatic apply_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        chk({name, "_rf_we"}, 64'(rf_we), 64'd0);
        chk({name, "_pending"}, 64'(pending_mask), 64'd0);
        chk({name, "_ready"}, 64'(req_ready), 64'b111);
        clear_reqs();
        log_base = log_n;
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [NREG-1:0] exp_mask;
        int              hit;
        if (!reset) begin
            exp_mask = '0;
            for (int k = log_base; k < log_n; k++)
                if (!consumed[k]) exp_mask[log_q[k].addr] = 1'b1;
            mon_checks++;
            if (pending_mask !== exp_mask) begin
                mon_errors++;
                $display("FAIL pending_mask: got %08h expected %08h", pending_mask, exp_mask);
            end
            if (rf_we) begin
                hit = -1;
                for (int k = log_base; k < log_n; k++)
                    if (hit < 0 && !consumed[k] && log_q[k].addr == rf_waddr) hit = k;
                mon_checks++;
                if (hit < 0) begin
                    mon_errors++;
                    $display("FAIL rf_write: unexpected write addr %0d data %08h", rf_waddr, rf_wdata);
                end else begin
                    if (log_q[hit].data !== rf_wdata) begin
                        mon_errors++;
                        $display("FAIL rf_wdata: addr %0d got %08h expected %08h", rf_waddr, rf_wdata, log_q[hit].data);
                    end
                    consumed[hit] = 1'b1;
                end
            end
        end
    end

    initial begin
        int unc;
        int acc;
        clear_reqs();
        #1 reset = 1'b1;
        #1;
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_waddr", 64'(rf_waddr), 64'd0);
        chk("reset_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_pending", 64'(pending_mask), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'b111);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        step();
        chk("idle_rf_we", 64'(rf_we), 64'd0);
        chk("idle_ready", 64'(req_ready), 64'b111);

        // Single write: output one cycle after acceptance, pending for two cycles.
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("single_accept", 64'(rdy_seen[1]), 64'd1);
        chk("single_e0_we", 64'(rf_we), 64'd0);
        chk("single_e0_pend", 64'(pending_mask[5]), 64'd1);
        step();
        chk("single_e1_we", 64'(rf_we), 64'd1);
        chk("single_e1_addr", 64'(rf_waddr), 64'd5);
        chk("single_e1_data", 64'(rf_wdata), 64'hDEADBEEF);
        chk("single_e1_pend", 64'(pending_mask[5]), 64'd1);
        step();
        chk("single_e2_we", 64'(rf_we), 64'd0);
        chk("single_e2_pend", 64'(pending_mask[5]), 64'd0);

        // Fairness: all three kept full, grants rotate 0,1,2 from a fresh pointer.
        apply_reset("rst_fair");
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
        step();
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
            step();
            chk($sformatf("rr_ready_%0d", c), 64'(rdy_seen), 64'(3'b001 << (c % 3)));
            chk($sformatf("rr_we_%0d", c), 64'(rf_we), 64'd1);
            chk($sformatf("rr_addr_%0d", c), 64'(rf_waddr), 64'((c % 3) + 1));
        end
        clear_reqs();
        repeat (5) step();

        // Same-cycle tie on address 7; requester 1 idles on 7 too, so it is blocked by requester 0.
        col_addr = 5'd7;
        col_q.delete();
        set_req(0, 1'b1, 5'd7, 32'h11);
        set_req(1, 1'b0, 5'd7, 32'h0);
        set_req(2, 1'b1, 5'd7, 32'h22);
        step();
        chk("tie_ready", 64'(rdy_seen), 64'b001);
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        acc = 0;
        for (int c = 0; c < 6 && acc == 0; c++) begin
            step();
            if (rdy_seen[2]) acc = 1;
        end
        set_req(2, 1'b0, 5'd0, 32'h0);
        repeat (4) step();
        chk("tie_count", 64'(col_q.size()), 64'd2);
        if (col_q.size() == 2) begin
            chk("tie_first", 64'(col_q[0]), 64'h11);
            chk("tie_second", 64'(col_q[1]), 64'h22);
        end

        // Register 0 writes are swallowed.
        set_req(0, 1'b1, 5'd0, 32'hCAFE0000);
        step();
        set_req(0, 1'b0, 5'd0, 32'h0);
        chk("zero_ready", 64'(rdy_seen[0]), 64'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("zero_we_%0d", c), 64'(rf_we), 64'd0);
            chk($sformatf("zero_pend_%0d", c), 64'(pending_mask), 64'd0);
        end

        // Occupied, ungranted slot 1 holding addr 9 blocks requester 0 on addr 9.
        apply_reset("rst_occ");
        col_addr = 5'd9;
        col_q.delete();
        set_req(0, 1'b1, 5'd4, 32'hA0A0A0A0);
        set_req(1, 1'b1, 5'd9, 32'hB1B1B1B1);
        step();
        set_req(0, 1'b1, 5'd9, 32'hC0C0C0C0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        step();
        chk("occ_blocked", 64'(rdy_seen[0]), 64'd0);
        step();
        chk("occ_released", 64'(rdy_seen[0]), 64'd1);
        set_req(0, 1'b0, 5'd0, 32'h0);
        repeat (4) step();
        chk("occ_count", 64'(col_q.size()), 64'd2);
        if (col_q.size() == 2) begin
            chk("occ_first", 64'(col_q[0]), 64'hB1B1B1B1);
            chk("occ_second", 64'(col_q[1]), 64'hC0C0C0C0);
        end

        // Mid-burst reset drops everything in flight.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(11 + i), $urandom);
        repeat (4) step();
        chk("burst_busy", 64'(rf_we), 64'd1);
        apply_reset("rst_mid");
        chk("post_rst_we", 64'(rf_we), 64'd0);

        // Random traffic over a small address range to provoke conflicts.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            step();
        end
        clear_reqs();
        repeat (8) step();
        unc = 0;
        for (int k = log_base; k < log_n; k++) if (!consumed[k]) unc++;
        chk("drain_all", 64'(unc), 64'd0);
        chk("drain_pending", 64'(pending_mask), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 drv_checks + mon_checks, drv_errors + mon_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the single write port of the 32×32 general-purpose register file between several write-back requesters, e.g. ALU, load unit and multiply/divide unit.
- Each requester hands over one write through a valid/ready handshake into a one-entry holding slot.
- A round-robin arbiter drains one slot per cycle into a registered write port that drives the register file's regWrite/rd/writeData.
- A pending-destination mask is exported so the issue stage can stall reads of registers with writes still in flight.

## Interface
Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width; register count is 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  requester i presents a write
- req_ready  out  NUM_REQ  requester i write accepted this cycle when valid&ready
- req_addr  in  NUM_REQ*ADDR_W  destination of requester i; slice i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  data of requester i; slice i at [i*DATA_W +: DATA_W]
- rf_we  out  1  registered write enable to the register file
- rf_waddr  out  ADDR_W  registered write address
- rf_wdata  out  DATA_W  registered write data
- pending_mask  out  2**ADDR_W  bit k = a write to register k is accepted but not yet committed

## Operation
- Per requester: slot_valid, slot_addr, slot_data.
- Acceptance, valid&ready at edge: loads the slot. Exception: addr 0 is accepted and discarded; it never occupies a slot and never produces rf_we.
- req_ready[i] = (!slot_valid[i] || grant[i]) && !conflict[i].
- conflict[i] is set by either:
  - an occupied, non-granted slot j≠i holding the same nonzero addr; or
  - a lower-index requester j<i presenting valid this cycle with the same nonzero addr.
  - Purpose: same-address writes commit in acceptance order, lower index wins ties.
  - req_ready may therefore depend combinationally on other requesters' valid/addr; requesters must not make valid depend on ready.
- Arbitration is combinational over slot_valid, round-robin:
  - The search starts at rr_ptr; grant is one-hot or zero.
  - On a grant to i: rr_ptr <= (i+1) mod NUM_REQ; rr_ptr is otherwise unchanged.
- Output register, updated every edge:
  - With a grant: rf_we<=1, rf_waddr<=slot_addr[g], rf_wdata<=slot_data[g], and slot g clears unless refilled in the same cycle.
  - With no grant: rf_we<=0; rf_waddr and rf_wdata hold their previous values.
- pending_mask = OR of decoded slot_addr over valid slots, OR decoded rf_waddr when rf_we=1. Bit 0 is always 0.

## Timing
- Reset values: all slots empty, rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, pending_mask=0, req_ready = all ones (no conflicts possible).
- Latency, accepted at edge E0:
  - Earliest grant is in the cycle after E0.
  - rf_we=1 after edge E1.
  - The register file commits at E2.
  - The pending_mask bit is set from after E0 through the cycle before E2.
- Throughput:
  - One write per cycle total.
  - A single continuously valid requester with no contention achieves one write per cycle, because the slot drains and refills on the same edge.
- Fairness: with all NUM_REQ slots occupied and kept refilled, each requester is granted exactly once in every NUM_REQ consecutive cycles.
- Reset mid-operation: asynchronous clear of all slots and outputs; accepted-but-uncommitted writes are lost.
  - rf_we drops immediately, with no partial write.
- Simultaneous refill and drain of one slot in one cycle: the new data loads and the old data goes to the output register.
- Each slot holds a single write, so there is no overflow condition; backpressure is via req_ready only.

## Structure
- Package regfile_wb_pkg holds:
  - defaults for NUM_REQ, DATA_W, ADDR_W;
  - NUM_REGS = 2**ADDR_W;
  - a slot record typedef {valid, addr, data}.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req vector, clk, reset, advance;
  - output: one-hot grant;
  - it owns rr_ptr.
- Address decode for pending_mask and the conflict comparators remain in the top-level module.

## Test plan
- Reset, then idle:
  - rf_we=0, pending_mask=0, req_ready=3'b111.
  - Assert reset mid-burst: outputs are cleared asynchronously before the next edge.
- Single write, requester 1, addr 5, data 0xDEADBEEF:
  - rf_we=1 with waddr 5 and wdata 0xDEADBEEF one cycle after acceptance.
  - pending_mask[5] is high exactly 2 cycles.
- All three requesters continuously valid, addrs 1/2/3:
  - grant order 0,1,2,0,1,2…;
  - each receives one grant per 3 cycles; rf_we stays high.
- Requesters 0 and 2 valid in the same cycle, both addr 7, data 0x11 and 0x22:
  - ready = 3'b001 in that cycle;
  - rf writes to 7 occur in order 0x11, then 0x22.
- Requester 0 writes addr 0:
  - accepted with req_ready=1;
  - rf_we never asserts; pending_mask stays 0.
- Slot 1 occupied with addr 9 and not granted, requester 0 presents addr 9:
  - req_ready[0]=0 until slot 1 is granted, then accepted;
  - commit order is slot 1's write, then requester 0's write.
